// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: register-index width, XLEN, issue FSM encoding
// and the opcode constants also used by decode.
package pipe_pkg;
  localparam int REG_W = 5;
  localparam int XLEN  = 64;
  localparam int NREGS = 1 << REG_W;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } issue_state_e;

  localparam logic [6:0] ALGORITHM     = 7'b0110011;
  localparam logic [6:0] ALGORITHM_IMM = 7'b0010011;
  localparam logic [6:0] LOAD          = 7'b0000011;

  // x0 never maps to a scoreboard bit.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
    logic [NREGS-1:0] oh;
    oh = '0;
    if (idx != '0) oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/drain bundle between inst_decode and the issue scoreboard.
interface hazard_scoreboard_if #(parameter int CNT_W = 4);
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_write_back;
  logic        id_load_flag;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic        wb_is_load;
  logic        drain_req;
  logic        issue_fire;
  logic        stall;
  logic [31:0] pending_mask;
  logic [CNT_W-1:0] load_cnt;
  logic        drain_done;
  logic        busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_write_back, id_load_flag, wb_en, wb_rd, wb_is_load, drain_req,
    input  issue_fire, stall, pending_mask, load_cnt, drain_done, busy
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_write_back, id_load_flag, wb_en, wb_rd, wb_is_load, drain_req,
    output issue_fire, stall, pending_mask, load_cnt, drain_done, busy
  );
endinterface

// File: rtl/hazard_scoreboard_hazard_check.sv
// Combinational RAW / WAW / load-credit evaluation against the writeback-bypassed
// scoreboard view.
module hazard_check
  import pipe_pkg::*;
#(
  parameter int MAX_LOADS = 4,
  parameter int CNT_W     = 4
) (
  input  logic [NREGS-1:0] pend_eff_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic             use_rs1_i,
  input  logic             use_rs2_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             write_back_i,
  input  logic             load_flag_i,
  input  logic [CNT_W-1:0] load_cnt_i,
  input  logic             ld_wb_i,
  output logic             raw_o,
  output logic             waw_o,
  output logic             credit_o,
  output logic             hazard_o
);
  logic [CNT_W:0] cnt_adj;

  // One extra bit so a stray load writeback at count 0 cannot wrap onto MAX_LOADS.
  assign cnt_adj  = {1'b0, load_cnt_i} - (CNT_W+1)'(ld_wb_i);

  assign raw_o    = (use_rs1_i && rs1_i != '0 && pend_eff_i[rs1_i]) ||
                    (use_rs2_i && rs2_i != '0 && pend_eff_i[rs2_i]);
  assign waw_o    = write_back_i && rd_i != '0 && pend_eff_i[rd_i];
  assign credit_o = load_flag_i && (cnt_adj == (CNT_W+1)'(MAX_LOADS));
  assign hazard_o = raw_o || waw_o || credit_o;
endmodule

// File: rtl/hazard_scoreboard.sv
// Issue scoreboard: pending-write mask, outstanding-load count and drain FSM.
// Define HAZARD_PERF_CNT_EN to add saturating stall/issue performance counters.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int MAX_LOADS = 4,
  parameter int CNT_W     = 4
) (
  input  logic CLK,
  input  logic reset,
  hazard_scoreboard_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_raw,
  output logic [31:0] perf_stall_load,
  output logic [31:0] perf_issue
`endif
);
  issue_state_e     state_q, state_d;
  logic [NREGS-1:0] pend_q, pend_d, pend_eff, clr, set;
  logic [CNT_W-1:0] load_q, load_d;
  logic             ld_wb, ld_inc, ld_dec;
  logic             raw, waw, credit, hazard;
  logic             issue_fire;

  assign clr      = bus.wb_en ? reg_onehot(bus.wb_rd) : '0;
  assign pend_eff = pend_q & ~clr;
  assign ld_wb    = bus.wb_en && bus.wb_is_load;

  hazard_check #(.MAX_LOADS(MAX_LOADS), .CNT_W(CNT_W)) u_hazard_check (
    .pend_eff_i   (pend_eff),
    .rs1_i        (bus.id_rs1),
    .rs2_i        (bus.id_rs2),
    .use_rs1_i    (bus.id_use_rs1),
    .use_rs2_i    (bus.id_use_rs2),
    .rd_i         (bus.id_rd),
    .write_back_i (bus.id_write_back),
    .load_flag_i  (bus.id_load_flag),
    .load_cnt_i   (load_q),
    .ld_wb_i      (ld_wb),
    .raw_o        (raw),
    .waw_o        (waw),
    .credit_o     (credit),
    .hazard_o     (hazard)
  );

  // Gated by reset so every output reads 0 while reset is held.
  assign issue_fire     = reset && bus.id_valid && (state_q == RUN) && !hazard;
  assign bus.issue_fire = issue_fire;
  assign bus.stall      = reset && bus.id_valid && !issue_fire;

  assign set    = (issue_fire && bus.id_write_back) ? reg_onehot(bus.id_rd) : '0;
  assign pend_d = pend_eff | set;

  assign ld_inc = issue_fire && bus.id_load_flag;
  assign ld_dec = ld_wb && (load_q != '0);

  always_comb begin
    load_d = load_q;
    if (ld_inc && !ld_dec)      load_d = load_q + CNT_W'(1);
    else if (!ld_inc && ld_dec) load_d = load_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.drain_req) state_d = DRAIN;
      DRAIN: begin
        if (!bus.drain_req)                          state_d = RUN;
        else if (pend_d == '0 && load_d == '0)       state_d = DONE;
      end
      DONE:    if (!bus.drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pend_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      load_q  <= load_d;
    end
  end

  assign bus.pending_mask = pend_q;
  assign bus.load_cnt     = load_q;
  assign bus.drain_done   = (state_q == DONE);
  assign bus.busy         = (pend_q != '0) || (load_q != '0);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_raw_q, perf_load_q, perf_issue_q;
  logic        stall_raw, stall_load_only;

  assign stall_raw       = bus.stall && raw;
  // Credit is the sole cause: no register hazard and the FSM would allow issue.
  assign stall_load_only = bus.stall && credit && !raw && !waw && (state_q == RUN);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      perf_raw_q   <= '0;
      perf_load_q  <= '0;
      perf_issue_q <= '0;
    end else begin
      if (stall_raw && perf_raw_q != '1)         perf_raw_q   <= perf_raw_q + 32'd1;
      if (stall_load_only && perf_load_q != '1)  perf_load_q  <= perf_load_q + 32'd1;
      if (issue_fire && perf_issue_q != '1)      perf_issue_q <= perf_issue_q + 32'd1;
    end
  end

  assign perf_stall_raw  = perf_raw_q;
  assign perf_stall_load = perf_load_q;
  assign perf_issue      = perf_issue_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MAX_LOADS=4): dependencies, x0, load
// credit, set/clear collision, drain handshake and asynchronous reset.
module tb_hazard_scoreboard;
  logic CLK;
  logic reset;
  int   total;
  int   passed;

  hazard_scoreboard_if #(.CNT_W(4)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_raw, perf_stall_load, perf_issue;
`endif

  hazard_scoreboard #(.MAX_LOADS(4), .CNT_W(4)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_raw  (perf_stall_raw),
    .perf_stall_load (perf_stall_load),
    .perf_issue      (perf_issue)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0;
    bus.id_use_rs2 = 0; bus.id_rd = 0; bus.id_write_back = 0; bus.id_load_flag = 0;
    bus.wb_en = 0; bus.wb_rd = 0; bus.wb_is_load = 0;
  endtask

  task automatic id_op(input logic [4:0] rd, input logic wbk, input logic ld,
                       input logic [4:0] rs1, input logic u1);
    bus.id_valid = 1; bus.id_rd = rd; bus.id_write_back = wbk; bus.id_load_flag = ld;
    bus.id_rs1 = rs1; bus.id_use_rs1 = u1; bus.id_rs2 = 0; bus.id_use_rs2 = 0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic ld);
    bus.wb_en = 1; bus.wb_rd = rd; bus.wb_is_load = ld;
  endtask

  task automatic test_reset();
    id_op(5'd3, 1, 0, 5'd0, 0);
    #1;
    total++; if (bus.issue_fire !== 1'b0) $display("FAIL rst_issue got=%0b exp=0", bus.issue_fire); else passed++;
    total++; if (bus.stall !== 1'b0) $display("FAIL rst_stall got=%0b exp=0", bus.stall); else passed++;
    total++; if (bus.pending_mask !== 32'h0 || bus.load_cnt !== 4'd0)
      $display("FAIL rst_state got=%h/%0d exp=0/0", bus.pending_mask, bus.load_cnt); else passed++;
    total++; if (bus.drain_done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL rst_flags got=%0b%0b exp=00", bus.drain_done, bus.busy); else passed++;
    idle();
  endtask

  task automatic test_back_to_back();
    id_op(5'd5, 1, 0, 5'd0, 0); #1;
    total++; if (bus.issue_fire !== 1'b1) $display("FAIL b2b_first got=%0b exp=1", bus.issue_fire); else passed++;
    cyc();
    id_op(5'd6, 1, 0, 5'd5, 1); #1;
    total++; if (bus.stall !== 1'b1 || bus.issue_fire !== 1'b0)
      $display("FAIL b2b_stall got=%0b/%0b exp=1/0", bus.stall, bus.issue_fire); else passed++;
    total++; if (bus.pending_mask !== 32'h20) $display("FAIL b2b_pend got=%h exp=00000020", bus.pending_mask); else passed++;
    cyc();
    wb(5'd5, 0); #1;
    total++; if (bus.issue_fire !== 1'b1 || bus.stall !== 1'b0)
      $display("FAIL b2b_bypass got=%0b/%0b exp=1/0", bus.issue_fire, bus.stall); else passed++;
    cyc();
    total++; if (bus.pending_mask !== 32'h40) $display("FAIL b2b_after got=%h exp=00000040", bus.pending_mask); else passed++;
    idle(); wb(5'd6, 0); cyc(); idle();
    total++; if (bus.pending_mask !== 32'h0 || bus.busy !== 1'b0)
      $display("FAIL b2b_clean got=%h/%0b exp=0/0", bus.pending_mask, bus.busy); else passed++;
  endtask

  task automatic test_x0();
    id_op(5'd0, 1, 0, 5'd0, 0); #1;
    total++; if (bus.issue_fire !== 1'b1) $display("FAIL x0_wr got=%0b exp=1", bus.issue_fire); else passed++;
    cyc();
    id_op(5'd0, 1, 0, 5'd0, 1); bus.id_rs2 = 0; bus.id_use_rs2 = 1; #1;
    total++; if (bus.stall !== 1'b0 || bus.issue_fire !== 1'b1)
      $display("FAIL x0_rd got=%0b/%0b exp=0/1", bus.stall, bus.issue_fire); else passed++;
    cyc(); idle();
    total++; if (bus.pending_mask !== 32'h0) $display("FAIL x0_pend got=%h exp=0", bus.pending_mask); else passed++;
    wb(5'd9, 0); cyc(); idle();
    total++; if (bus.pending_mask !== 32'h0 || bus.load_cnt !== 4'd0)
      $display("FAIL wb_nonpend got=%h/%0d exp=0/0", bus.pending_mask, bus.load_cnt); else passed++;
  endtask

  task automatic test_load_credit();
    for (int r = 1; r <= 4; r++) begin
      id_op(5'(r), 1, 1, 5'd0, 0); #1;
      total++; if (bus.issue_fire !== 1'b1) $display("FAIL ld_issue%0d got=%0b exp=1", r, bus.issue_fire); else passed++;
      cyc();
    end
    total++; if (bus.load_cnt !== 4'd4 || bus.pending_mask !== 32'h1E)
      $display("FAIL ld_full got=%0d/%h exp=4/0000001e", bus.load_cnt, bus.pending_mask); else passed++;
    id_op(5'd8, 1, 1, 5'd0, 0); #1;
    total++; if (bus.stall !== 1'b1) $display("FAIL ld_credit_stall got=%0b exp=1", bus.stall); else passed++;
    wb(5'd1, 1); #1;
    total++; if (bus.issue_fire !== 1'b1) $display("FAIL ld_credit_bypass got=%0b exp=1", bus.issue_fire); else passed++;
    cyc(); idle();
    total++; if (bus.load_cnt !== 4'd4 || bus.pending_mask !== 32'h11C)
      $display("FAIL ld_swap got=%0d/%h exp=4/0000011c", bus.load_cnt, bus.pending_mask); else passed++;
    wb(5'd2, 1); cyc(); wb(5'd3, 1); cyc(); wb(5'd4, 1); cyc(); wb(5'd8, 1); cyc(); idle();
    total++; if (bus.load_cnt !== 4'd0 || bus.busy !== 1'b0)
      $display("FAIL ld_drain got=%0d/%0b exp=0/0", bus.load_cnt, bus.busy); else passed++;
    wb(5'd0, 1); cyc(); idle();
    total++; if (bus.load_cnt !== 4'd0) $display("FAIL ld_sat0 got=%0d exp=0", bus.load_cnt); else passed++;
  endtask

  task automatic test_collision();
    id_op(5'd7, 1, 0, 5'd0, 0); cyc();
    id_op(5'd7, 1, 0, 5'd0, 0); #1;
    total++; if (bus.stall !== 1'b1) $display("FAIL col_waw got=%0b exp=1", bus.stall); else passed++;
    wb(5'd7, 0); #1;
    total++; if (bus.issue_fire !== 1'b1) $display("FAIL col_issue got=%0b exp=1", bus.issue_fire); else passed++;
    cyc(); idle();
    total++; if (bus.pending_mask !== 32'h80) $display("FAIL col_setwins got=%h exp=00000080", bus.pending_mask); else passed++;
    wb(5'd7, 0); cyc(); idle();
  endtask

  task automatic test_drain();
    id_op(5'd10, 1, 1, 5'd0, 0); cyc();
    id_op(5'd11, 1, 1, 5'd0, 0); cyc(); idle();
    total++; if (bus.load_cnt !== 4'd2) $display("FAIL dr_loads got=%0d exp=2", bus.load_cnt); else passed++;
    bus.drain_req = 1; cyc();
    id_op(5'd12, 1, 0, 5'd0, 0); wb(5'd10, 1); #1;
    total++; if (bus.issue_fire !== 1'b0 || bus.stall !== 1'b1)
      $display("FAIL dr_block got=%0b/%0b exp=0/1", bus.issue_fire, bus.stall); else passed++;
    cyc();
    wb(5'd11, 1); #1;
    total++; if (bus.drain_done !== 1'b0) $display("FAIL dr_early got=%0b exp=0", bus.drain_done); else passed++;
    cyc(); bus.wb_en = 0; bus.wb_is_load = 0; #1;
    total++; if (bus.drain_done !== 1'b1 || bus.busy !== 1'b0 || bus.issue_fire !== 1'b0)
      $display("FAIL dr_done got=%0b/%0b/%0b exp=1/0/0", bus.drain_done, bus.busy, bus.issue_fire); else passed++;
    bus.drain_req = 0; cyc();
    total++; if (bus.issue_fire !== 1'b1 || bus.drain_done !== 1'b0)
      $display("FAIL dr_resume got=%0b/%0b exp=1/0", bus.issue_fire, bus.drain_done); else passed++;
    cyc(); idle(); wb(5'd12, 0); cyc(); idle();
  endtask

  task automatic test_reset_mid_drain();
    id_op(5'd5, 1, 0, 5'd0, 0); cyc();
    id_op(5'd6, 1, 0, 5'd0, 0); cyc(); idle();
    bus.drain_req = 1; cyc();
    id_op(5'd13, 1, 0, 5'd0, 0); #1;
    total++; if (bus.pending_mask !== 32'h60 || bus.issue_fire !== 1'b0)
      $display("FAIL rmd_pre got=%h/%0b exp=00000060/0", bus.pending_mask, bus.issue_fire); else passed++;
    reset = 0; #1;
    total++; if (bus.pending_mask !== 32'h0 || bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.issue_fire !== 1'b0)
      $display("FAIL rmd_async got=%h/%0b/%0b/%0b exp=0/0/0/0", bus.pending_mask, bus.busy, bus.stall, bus.issue_fire); else passed++;
    bus.drain_req = 0; #1; reset = 1; #1;
    total++; if (bus.issue_fire !== 1'b1 || bus.drain_done !== 1'b0)
      $display("FAIL rmd_run got=%0b/%0b exp=1/0", bus.issue_fire, bus.drain_done); else passed++;
    cyc(); idle();
    total++; if (bus.pending_mask !== 32'h2000) $display("FAIL rmd_after got=%h exp=00002000", bus.pending_mask); else passed++;
  endtask

  initial begin
    total = 0; passed = 0;
    reset = 0; bus.drain_req = 0; idle();
    #2 test_reset();
    #10 reset = 1;
    cyc();
    test_back_to_back();
    test_x0();
    test_load_credit();
    test_collision();
    test_drain();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
